seq_fixedpoint_to_float32: RTL and testbench
============================================

Name: seq_fixedpoint_to_float32

Overview:
- Multi-cycle converter from signed two's-complement fixed point (WOI integer bits, WOF fraction bits) to IEEE-754 single precision. It is the reverse direction of the team's combinational float32-to-fixed converter.
- Normalises the magnitude one bit per cycle under a small FSM, then rounds and packs the result.
- Valid/ready handshakes on both sides, so it can sit between streaming fixed-point datapaths and float32 consumers without a wide leading-zero counter.

Parameters:
- WOI, 8, integer bits of input including sign; 1..127.
- WOF, 8, fraction bits of input; 0..126.
- ROUND, 1, bit; 1 = round to nearest with ties away from zero; 0 = truncate toward zero.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstn  input  1  synchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  converter can accept; equals (state==IDLE).
- in  input  WOI+WOF  signed fixed-point value; value = in / 2^WOF.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out  output  32  float32 result {sign, exp[7:0], man[22:0]}.

Behaviour:
- W = WOI+WOF. States are IDLE, NORM and DONE, held in a registered state plus sign, mag[W-1:0], e[8:0] and out.
- Reset (rstn low at an edge):
  - state=IDLE, out=32'h0, sign=0, mag=0.
  - out_valid=0; in_ready=1 from the first edge after reset.
  - Reset mid-operation aborts the conversion; no output is produced for it.
- IDLE:
  - On in_valid && in_ready, register sign=in[W-1], mag=|in|, e=127+WOI-1, then go to NORM.
  - |in| is computed as an unsigned W-bit negation, so the most negative input gives mag=2^(W-1) correctly.
- NORM, one step per cycle:
  - If mag==0: out=32'h00000000 (+0.0, even for sign input 0), go to DONE.
  - Else if mag[W-1]==1: pack the result into out, go to DONE.
  - Else: mag<=mag<<1, e<=e-1, stay in NORM.
- Pack rules:
  - Mantissa is the 23 bits below the leading one, zero-padded on the right when W<24.
  - With ROUND=1 and W>=25, add the bit just below the mantissa LSB.
  - If the mantissa carries out (all ones + 1), set mantissa=0 and e=e+1.
  - out={sign, e[7:0], man}.
  - Parameter limits keep e within 1..254, so no inf/denormal paths exist.
- Latency:
  - k = leading zeros of mag.
  - out_valid rises k+1 cycles after the accept edge; for zero input it rises 1 cycle after.
  - Maximum latency is W cycles.
- DONE:
  - out_valid=1; out and out_valid are held stable while out_ready=0.
  - On out_ready, go to IDLE; in_ready returns 1 on the next cycle.
- No overlap: in_ready=0 in NORM and DONE. in is ignored when in_ready=0.
- The output is registered; there is no combinational path from in or out_ready to out or out_valid.

Decomposition:
- Shared package (fixedpoint_pkg):
  - State enum {IDLE, NORM, DONE}.
  - Constants FP32_BIAS=127, FP32_EXP_W=8, FP32_MAN_W=23.
  - A pure function that rounds and packs {sign, e, normalised mag} into 32 bits.
- No sub-module; the FSM and datapath fit in one module.

Test Plan:
- WOI=8, WOF=8, in=16'h0100 (1.0) -> out=32'h3F800000, out_valid 8 cycles after accept (k=7).
- in=16'hFF00 (-1.0) -> out=32'hBF800000. in=16'h8000 (-128.0) -> out=32'hC3000000 at latency 1.
- in=16'h0000 -> out=32'h00000000 at latency 1. in=16'h0001 -> out=32'h3B800000 at latency 16.
- WOI=16, WOF=16, in=32'h01000001 -> out=32'h43800001 with ROUND=1, 32'h43800000 with ROUND=0.
  - Also in=32'h01FFFFFF with ROUND=1 -> out=32'h44000000 (mantissa carry).
- Backpressure: hold out_ready=0 for 10 cycles.
  - out and out_valid stay stable, in_ready=0, and an in_valid pulse in that window is ignored.
  - Raise out_ready; in_ready=1 on the next cycle.
- Drive rstn=0 for one edge during NORM of in=16'h0001.
  - out_valid never asserts, out=0, in_ready=1.
  - The next conversion completes correctly.

Source files
------------

// File: rtl/fixedpoint_pkg.sv
// Shared types and helpers for the fixed-point to float32 converter.
package fixedpoint_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  // frac holds the 23 mantissa bits below the leading one plus the guard bit.
  function automatic logic [31:0] fp32_pack(
    input logic        sign,
    input logic [8:0]  e,
    input logic [23:0] frac,
    input logic        rnd
  );
    logic [FP32_MAN_W:0]   sum;
    logic [8:0]            ex;
    logic [FP32_MAN_W-1:0] man;
    sum = {1'b0, frac[23:1]} + {{FP32_MAN_W{1'b0}}, rnd & frac[0]};
    ex  = e;
    man = sum[FP32_MAN_W-1:0];
    if (sum[FP32_MAN_W]) begin
      man = '0;
      ex  = e + 9'd1;
    end
    return {sign, ex[FP32_EXP_W-1:0], man};
  endfunction

endpackage

// File: rtl/seq_fixedpoint_to_float32.sv
// Signed fixed point to float32, normalising one bit per cycle.
module seq_fixedpoint_to_float32
  import fixedpoint_pkg::*;
#(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WOI+WOF-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out
);

  localparam int W = WOI + WOF;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [8:0]     e_q, e_d;
  logic [31:0]    out_q, out_d;
  logic [23:0]    frac;

  // Bits below the leading one, zero-padded when W is narrow.
  assign frac = 24'({mag_q, 24'b0} >> (W - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    e_d     = e_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in[W-1];
          mag_d   = in[W-1] ? ('0 - in) : in;
          e_d     = 9'(FP32_BIAS + WOI - 1);
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          out_d   = '0;
          state_d = DONE;
        end else if (mag_q[W-1]) begin
          out_d   = fp32_pack(sign_q, e_q, frac, ROUND != 0);
          state_d = DONE;
        end else begin
          mag_d = mag_q << 1;
          e_d   = e_q - 9'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      e_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_seq_fixedpoint_to_float32.sv
// Randomised and directed bench for seq_fixedpoint_to_float32.
module tb_seq_fixedpoint_to_float32;

  logic        clk = 0;
  logic        rstn = 0;
  logic        in_valid = 0;
  logic        out_ready = 1;
  logic [31:0] bus = 0;
  logic [2:0]  ir, ov, pov;
  logic [31:0] o0, o1, o2;
  logic [31:0] ob [3];
  logic [31:0] hold [3];
  logic [31:0] ev [3];
  int          el [3];
  int          acc [3];
  logic [31:0] last_out [3];
  int          last_lat [3];
  logic [2:0]  pend = 0;
  int          cyc = 0;
  int          npass = 0;
  int          ntot = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_fixedpoint_to_float32 #(.WOI(8), .WOF(8), .ROUND(1)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[0]),
    .in(bus[15:0]), .out_valid(ov[0]), .out_ready(out_ready), .out(o0));

  seq_fixedpoint_to_float32 #(.WOI(16), .WOF(16), .ROUND(1)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[1]),
    .in(bus), .out_valid(ov[1]), .out_ready(out_ready), .out(o1));

  seq_fixedpoint_to_float32 #(.WOI(16), .WOF(16), .ROUND(0)) dut_c (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[2]),
    .in(bus), .out_valid(ov[2]), .out_ready(out_ready), .out(o2));

  always_comb begin
    ob[0] = o0;
    ob[1] = o1;
    ob[2] = o2;
  end

  task automatic chk(string nm, int k, longint got, longint exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, got, exp);
  endtask

  // Value of the input taken as a w-bit signed number scaled by 2^-wof.
  function automatic logic [31:0] model(logic [31:0] raw, int w, int wof,
                                        bit rnd);
    longint unsigned u, mag, man;
    int p, ex;
    bit s;
    u   = raw & ((64'd1 << w) - 1);
    s   = ((u >> (w - 1)) & 1) != 0;
    mag = s ? ((64'd1 << w) - u) : u;
    if (mag == 0) return 32'h0;
    p = 63;
    while (((mag >> p) & 1) == 0) p--;
    ex = 127 + p - wof;
    if (p >= 23) begin
      man = mag >> (p - 23);
      if (rnd && p >= 24) man += (mag >> (p - 24)) & 1;
      if (man == (64'd1 << 24)) begin
        man = 64'd1 << 23;
        ex++;
      end
    end else begin
      man = mag << (23 - p);
    end
    return {s, 8'(ex), man[22:0]};
  endfunction

  function automatic int mlat(logic [31:0] raw, int w);
    longint unsigned u, mag;
    int p;
    u   = raw & ((64'd1 << w) - 1);
    mag = ((u >> (w - 1)) & 1) != 0 ? ((64'd1 << w) - u) : u;
    if (mag == 0) return 1;
    p = 63;
    while (((mag >> p) & 1) == 0) p--;
    return w - p;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && !pov[k]) begin
        if (!pend[k]) begin
          chk("unexpected_valid", k, 1, 0);
        end else begin
          last_out[k] = ob[k];
          last_lat[k] = cyc - acc[k];
          chk("out", k, ob[k], ev[k]);
          chk("latency", k, cyc - acc[k], el[k]);
          pend[k] = 1'b0;
        end
      end
      pov[k] = ov[k];
    end
  end

  task automatic send(logic [31:0] v);
    int n = 0;
    while (ir != 3'b111 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, ir, 3'b111);
    bus      = v;
    in_valid = 1;
    ev[0] = model(v, 16, 8, 1);
    ev[1] = model(v, 32, 16, 1);
    ev[2] = model(v, 32, 16, 0);
    el[0] = mlat(v, 16);
    el[1] = mlat(v, 32);
    el[2] = el[1];
    @(posedge clk);
    #1;
    in_valid = 0;
    bus      = $urandom;
    for (int k = 0; k < 3; k++) acc[k] = cyc;
    pend = 3'b111;
  endtask

  task automatic wait_idle(bit rr);
    int n = 0;
    while ((pend != 0 || ir != 3'b111) && n < 300) begin
      @(negedge clk);
      out_ready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, pend, 0);
    out_ready = 1;
    @(negedge clk);
  endtask

  task automatic run1(logic [31:0] v);
    send(v);
    wait_idle(0);
  endtask

  initial begin
    pov = 0;
    chk("model_one", 0, model(32'h0100, 16, 8, 1), 32'h3F800000);
    chk("model_neg_one", 0, model(32'hFF00, 16, 8, 1), 32'hBF800000);
    chk("model_rnd", 1, model(32'h01000001, 32, 16, 1), 32'h43800001);
    chk("model_trunc", 2, model(32'h01000001, 32, 16, 0), 32'h43800000);
    chk("model_carry", 1, model(32'h01FFFFFF, 32, 16, 1), 32'h44000000);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", k, ir[k], 1);
      chk("reset_out_valid", k, ov[k], 0);
      chk("reset_out", k, ob[k], 0);
    end
    rstn = 1;
    @(negedge clk);

    run1(32'h0000_0100);
    chk("one_val", 0, last_out[0], 32'h3F800000);
    chk("one_lat", 0, last_lat[0], 8);
    run1(32'h0000_FF00);
    chk("neg_one_val", 0, last_out[0], 32'hBF800000);
    run1(32'h0000_8000);
    chk("most_neg_val", 0, last_out[0], 32'hC3000000);
    chk("most_neg_lat", 0, last_lat[0], 1);
    run1(32'h0000_0000);
    chk("zero_val", 0, last_out[0], 32'h0);
    chk("zero_lat", 0, last_lat[0], 1);
    chk("zero_lat", 1, last_lat[1], 1);
    run1(32'h0100_0001);
    chk("lsb_val", 0, last_out[0], 32'h3B800000);
    chk("lsb_lat", 0, last_lat[0], 16);
    chk("rnd_val", 1, last_out[1], 32'h43800001);
    chk("trunc_val", 2, last_out[2], 32'h43800000);
    run1(32'h01FF_FFFF);
    chk("carry_val", 1, last_out[1], 32'h44000000);

    // Backpressure with an ignored input pulse.
    out_ready = 0;
    send(32'h0000_0100);
    for (int n = 0; n < 100 && ov != 3'b111; n++) @(negedge clk);
    chk("bp_all_valid", 0, ov, 3'b111);
    for (int k = 0; k < 3; k++) hold[k] = ob[k];
    for (int i = 0; i < 10; i++) begin
      bus      = 32'h0000_0001;
      in_valid = (i == 4);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("bp_out_stable", k, ob[k], hold[k]);
        chk("bp_valid_held", k, ov[k], 1);
        chk("bp_in_ready", k, ir[k], 0);
      end
    end
    in_valid  = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 0, ir, 3'b111);
    chk("bp_release_valid", 0, ov, 3'b000);
    repeat (40) @(negedge clk);
    chk("bp_no_start", 0, ir, 3'b111);

    // Reset in the middle of normalisation.
    send(32'h0000_0001);
    repeat (3) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    pend = 0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_in_ready", k, ir[k], 1);
      chk("abort_out_valid", k, ov[k], 0);
      chk("abort_out", k, ob[k], 0);
    end
    repeat (40) @(negedge clk);
    chk("abort_quiet", 0, ov, 3'b000);
    run1(32'h0000_0100);
    chk("after_abort_val", 0, last_out[0], 32'h3F800000);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      send(v);
      wait_idle(1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
